universal_shift_reg_n: RTL and testbench
========================================

Name: universal_shift_reg_n

Overview:
- Parametrised, WIDTH-bit universal shift register. Successor to the fixed 4-bit universal shift register.
- Adds serial-in and serial-out, rotate and arithmetic modes, a clock enable, and a self-timed burst engine that performs COUNT single-bit steps after a START pulse, with BUSY/DONE handshake.
- Sits between datapath registers and serial links or barrel-less shift sequencing.

Parameters:
WIDTH, 8, register width in bits (>=2)
CNT_W, 4, width of burst COUNT port and internal step counter

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
ENABLE  input  1  clock enable for MODE ops and burst steps
MODE  input  3  operation select (see Behaviour)
DATAIN  input  WIDTH  parallel load data
SIN_R  input  1  serial in, enters MSB on shift right
SIN_L  input  1  serial in, enters LSB on shift left
START  input  1  burst request pulse
BDIR  input  1  burst direction: 0 = right, 1 = left
BROT  input  1  burst type: 0 = logical shift (zero fill), 1 = rotate
COUNT  input  CNT_W  burst step count
DATAOUT  output  WIDTH  register contents
SOUT_R  output  1  DATAOUT[0], combinational
SOUT_L  output  1  DATAOUT[WIDTH-1], combinational
BUSY  output  1  high while burst is stepping
DONE  output  1  one-cycle pulse after the final burst step

Behaviour:
- Reset (reset=0, async): DATAOUT=0, step counter=0, state=IDLE, BUSY=0, DONE=0. Takes effect immediately, including mid-burst; the burst is aborted with no DONE.
- MODE decode, applied at a clock edge only in IDLE with ENABLE=1 and START=0:
  - 000 hold
  - 001 shift right: {SIN_R, D[W-1:1]}
  - 010 shift left: {D[W-2:0], SIN_L}
  - 011 parallel load DATAIN
  - 100 rotate right: {D[0], D[W-1:1]}
  - 101 rotate left: {D[W-2:0], D[W-1]}
  - 110 arithmetic shift right: {D[W-1], D[W-1:1]}
  - 111 reserved, hold
- ENABLE=0 in IDLE: hold, regardless of MODE.
- FSM states:
  - IDLE:
    - START=1 (ENABLE ignored) latches BDIR, BROT and COUNT. No MODE op this edge; START has priority.
    - Next state is RUN if COUNT!=0, else DONE_ST.
  - RUN:
    - BUSY=1.
    - Each edge with ENABLE=1 performs one step (per latched BDIR/BROT; logical shift fills 0) and decrements the counter.
    - When the counter==1 at that edge, go to DONE_ST.
    - ENABLE=0 stalls: no step, no decrement, stay in RUN.
    - MODE and START are ignored.
  - DONE_ST: DONE=1, BUSY=0, DATAOUT held. Next state IDLE unconditionally. START here is ignored.
- Latency:
  - COUNT=N>0: START edge, then exactly N step edges (stalls excluded). DONE is high in the cycle after the last step. BUSY is high for N cycles plus stalls.
  - COUNT=0: DONE is high the cycle after START, with DATAOUT unchanged.
- COUNT>WIDTH is legal:
  - Rotate wraps modulo WIDTH.
  - Logical shift yields all zeros after WIDTH steps.
- BUSY and DONE are registered (state-decoded). SOUT_R and SOUT_L follow DATAOUT combinationally.
- Latched burst controls are immune to input changes during RUN.

Test Plan:
- Reset and load: reset=0 with DATAOUT nonzero -> DATAOUT=0x00 immediately without a clock. Release reset; MODE=011, DATAIN=0xA5 -> DATAOUT=0xA5, SOUT_R=1, SOUT_L=1.
- MODE ops from 0xA5, each applied independently:
  - 001 with SIN_R=0 -> 0x52
  - 010 with SIN_L=1 -> 0x4B
  - 100 -> 0xD2
  - 101 -> 0x4B
  - 110 -> 0xD2
  - 111 -> 0xA5
  - ENABLE=0 with any MODE -> 0xA5
- Burst rotate: from 0x81, START, BDIR=1, BROT=1, COUNT=3 -> BUSY high 3 cycles, DATAOUT 0x03, 0x06, 0x0C, then DONE high 1 cycle, back to IDLE.
- Burst shift with stall and overflow count: from 0xFF, BDIR=0, BROT=0, COUNT=10, ENABLE low 2 cycles mid-burst -> BUSY high 12 cycles, final DATAOUT=0x00, a single DONE pulse. MODE/START toggled during RUN have no effect.
- COUNT=0 and START priority: START with COUNT=0 and MODE=011 -> DATAOUT unchanged, BUSY never high, DONE high the next cycle.
- Reset mid-burst: assert reset=0 during RUN -> DATAOUT=0, BUSY=0, and no DONE. After release, a new burst runs normally.

Source files
------------

// File: rtl/universal_shift_reg_n.sv
// WIDTH-bit universal shift register with serial I/O, rotate/arith modes and a counted burst engine.
// Latency: MODE ops take effect at the next edge; a burst takes COUNT enabled edges, then DONE for one cycle.
// Backpressure: ENABLE low holds the register in IDLE and stalls RUN without consuming a step.
module universal_shift_reg_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ENABLE,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] DATAIN,
    input  logic             SIN_R,
    input  logic             SIN_L,
    input  logic             START,
    input  logic             BDIR,
    input  logic             BROT,
    input  logic [CNT_W-1:0] COUNT,
    output logic [WIDTH-1:0] DATAOUT,
    output logic             SOUT_R,
    output logic             SOUT_L,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE_ST = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q,  data_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               dir_q,   dir_d;
    logic               rot_q,   rot_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;
    logic [WIDTH-1:0]   step_val;

    // One burst step: the bit shifted out re-enters on rotate, otherwise zero fill.
    always_comb begin
        if (dir_q) begin
            step_val = {data_q[WIDTH-2:0], rot_q & data_q[WIDTH-1]};
        end else begin
            step_val = {rot_q & data_q[0], data_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        rot_d   = rot_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    dir_d   = BDIR;
                    rot_d   = BROT;
                    cnt_d   = COUNT;
                    state_d = (COUNT != '0) ? RUN : DONE_ST;
                end else if (ENABLE) begin
                    case (MODE)
                        3'b001:  data_d = {SIN_R, data_q[WIDTH-1:1]};
                        3'b010:  data_d = {data_q[WIDTH-2:0], SIN_L};
                        3'b011:  data_d = DATAIN;
                        3'b100:  data_d = {data_q[0], data_q[WIDTH-1:1]};
                        3'b101:  data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                        3'b110:  data_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                        default: data_d = data_q;
                    endcase
                end
            end
            RUN: begin
                if (ENABLE) begin
                    data_d = step_val;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE_ST;
                    end
                end
            end
            DONE_ST: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE_ST);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            rot_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            rot_q   <= rot_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign DATAOUT = data_q;
    assign SOUT_R  = data_q[0];
    assign SOUT_L  = data_q[WIDTH-1];
    assign BUSY    = busy_q;
    assign DONE    = done_q;

endmodule

// File: tb/tb_universal_shift_reg_n.sv
// Directed bench for universal_shift_reg_n: MODE ops, bursts with stalls, COUNT=0 and reset abort.
module tb_universal_shift_reg_n;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             ENABLE;
    logic [2:0]       MODE;
    logic [WIDTH-1:0] DATAIN;
    logic             SIN_R;
    logic             SIN_L;
    logic             START;
    logic             BDIR;
    logic             BROT;
    logic [CNT_W-1:0] COUNT;
    logic [WIDTH-1:0] DATAOUT;
    logic             SOUT_R;
    logic             SOUT_L;
    logic             BUSY;
    logic             DONE;

    int errors = 0;
    int checks = 0;

    universal_shift_reg_n #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock   (clock),
        .reset   (reset),
        .ENABLE  (ENABLE),
        .MODE    (MODE),
        .DATAIN  (DATAIN),
        .SIN_R   (SIN_R),
        .SIN_L   (SIN_L),
        .START   (START),
        .BDIR    (BDIR),
        .BROT    (BROT),
        .COUNT   (COUNT),
        .DATAOUT (DATAOUT),
        .SOUT_R  (SOUT_R),
        .SOUT_L  (SOUT_L),
        .BUSY    (BUSY),
        .DONE    (DONE)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [WIDTH-1:0] val);
        START  = 1'b0;
        ENABLE = 1'b1;
        MODE   = 3'b011;
        DATAIN = val;
        tick();
        MODE   = 3'b000;
    endtask

    // MODE op table applied to 0xA5: mode, sin_r, sin_l, enable, expected
    logic [2:0] t_mode [8] = '{3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111, 3'b011, 3'b000};
    logic       t_sinr [8] = '{1'b0,   1'b0,   1'b1,   1'b0,   1'b0,   1'b1,   1'b1,   1'b1};
    logic       t_sinl [8] = '{1'b0,   1'b1,   1'b1,   1'b0,   1'b0,   1'b1,   1'b1,   1'b1};
    logic       t_en   [8] = '{1'b1,   1'b1,   1'b1,   1'b1,   1'b1,   1'b1,   1'b0,   1'b1};
    logic [7:0] t_exp  [8] = '{8'h52,  8'h4B,  8'hD2,  8'h4B,  8'hD2,  8'hA5,  8'hA5,  8'hA5};

    int busy_cnt;
    int done_cnt;

    initial begin
        reset = 1'b0; ENABLE = 1'b0; MODE = 3'b000; DATAIN = '0;
        SIN_R = 1'b0; SIN_L = 1'b0; START = 1'b0; BDIR = 1'b0; BROT = 1'b0; COUNT = '0;
        #12;
        check("rst_data", 32'(DATAOUT), 32'h00);
        check("rst_busy", 32'(BUSY), 32'h0);
        check("rst_done", 32'(DONE), 32'h0);
        reset = 1'b1;
        tick();

        load(8'hA5);
        check("load_a5", 32'(DATAOUT), 32'hA5);
        check("load_sout_r", 32'(SOUT_R), 32'h1);
        check("load_sout_l", 32'(SOUT_L), 32'h1);

        // Asynchronous reset with no clock edge in between
        reset = 1'b0;
        #2;
        check("async_rst", 32'(DATAOUT), 32'h00);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            load(8'hA5);
            MODE   = t_mode[i];
            SIN_R  = t_sinr[i];
            SIN_L  = t_sinl[i];
            ENABLE = t_en[i];
            DATAIN = 8'h00;
            tick();
            check($sformatf("mode_%0d_en%0d", t_mode[i], t_en[i]), 32'(DATAOUT), 32'(t_exp[i]));
        end

        // Burst rotate left by 3 from 0x81; START wins over a simultaneous load
        load(8'h81);
        START = 1'b1; BDIR = 1'b1; BROT = 1'b1; COUNT = 4'd3;
        MODE = 3'b011; DATAIN = 8'h55; ENABLE = 1'b1;
        tick();
        START = 1'b0; MODE = 3'b000;
        check("rot_start_data", 32'(DATAOUT), 32'h81);
        check("rot_start_busy", 32'(BUSY), 32'h1);
        tick();
        check("rot_s1_data", 32'(DATAOUT), 32'h03);
        check("rot_s1_busy", 32'(BUSY), 32'h1);
        tick();
        check("rot_s2_data", 32'(DATAOUT), 32'h06);
        check("rot_s2_busy", 32'(BUSY), 32'h1);
        tick();
        check("rot_s3_data", 32'(DATAOUT), 32'h0C);
        check("rot_s3_busy", 32'(BUSY), 32'h0);
        check("rot_done", 32'(DONE), 32'h1);
        tick();
        check("rot_idle_done", 32'(DONE), 32'h0);
        check("rot_idle_data", 32'(DATAOUT), 32'h0C);

        // Logical right shift by 10 with a 2-cycle stall and noisy MODE/START
        load(8'hFF);
        START = 1'b1; BDIR = 1'b0; BROT = 1'b0; COUNT = 4'd10; ENABLE = 1'b1;
        tick();
        busy_cnt = BUSY ? 1 : 0;
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            ENABLE = !(i == 4 || i == 5);
            START  = (i % 3 == 0) && (i < 11);
            BDIR   = 1'b1;
            BROT   = 1'b1;
            MODE   = 3'b011;
            DATAIN = 8'hFF;
            tick();
            if (BUSY) busy_cnt++;
            if (DONE) begin
                done_cnt++;
                break;
            end
        end
        START = 1'b0; MODE = 3'b000; ENABLE = 1'b1;
        check("shf_busy_cycles", 32'(busy_cnt), 32'd12);
        check("shf_done_seen", 32'(done_cnt), 32'd1);
        check("shf_final_data", 32'(DATAOUT), 32'h00);
        tick();
        check("shf_single_done", 32'(DONE), 32'h0);
        check("shf_idle_busy", 32'(BUSY), 32'h0);

        // COUNT=0: immediate DONE, no BUSY, load suppressed
        load(8'h3C);
        START = 1'b1; COUNT = 4'd0; MODE = 3'b011; DATAIN = 8'hFF; ENABLE = 1'b1;
        tick();
        START = 1'b0; MODE = 3'b000;
        check("c0_busy", 32'(BUSY), 32'h0);
        check("c0_done", 32'(DONE), 32'h1);
        check("c0_data", 32'(DATAOUT), 32'h3C);
        tick();
        check("c0_done_clr", 32'(DONE), 32'h0);
        check("c0_busy_idle", 32'(BUSY), 32'h0);

        // Reset during RUN aborts the burst with no DONE
        START = 1'b1; COUNT = 4'd5; BDIR = 1'b1; BROT = 1'b1;
        tick();
        START = 1'b0;
        tick();
        check("mid_step1", 32'(DATAOUT), 32'h78);
        reset = 1'b0;
        #2;
        check("mid_rst_data", 32'(DATAOUT), 32'h00);
        check("mid_rst_busy", 32'(BUSY), 32'h0);
        check("mid_rst_done", 32'(DONE), 32'h0);
        reset = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (DONE || BUSY) done_cnt++;
        end
        check("mid_no_resume", 32'(done_cnt), 32'd0);

        // Fresh burst after the abort: rotate right by 2 from 0x01
        load(8'h01);
        START = 1'b1; COUNT = 4'd2; BDIR = 1'b0; BROT = 1'b1;
        tick();
        START = 1'b0;
        check("new_busy", 32'(BUSY), 32'h1);
        tick();
        check("new_s1", 32'(DATAOUT), 32'h80);
        tick();
        check("new_s2", 32'(DATAOUT), 32'h40);
        check("new_done", 32'(DONE), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
